// File: rtl/wave_dac_pkg.sv
// Shared constants, register indices and mode codes for the wave_dac output stage.
// Saturation helper lives here so the top and any future users agree on sample width.
package wave_dac_pkg;

   localparam logic [7:0] BLOCK_SEL = 8'h05;

   localparam logic [1:0] REG_CTRL  = 2'd0;
   localparam logic [1:0] REG_DIV   = 2'd1;
   localparam logic [1:0] REG_SHIFT = 2'd2;
   localparam logic [1:0] REG_FIFO  = 2'd3;

   typedef enum logic [1:0] {
      MODE_OFF = 2'd0,
      MODE_SD  = 2'd1,
      MODE_PWM = 2'd2
   } mode_t;

   localparam int                  SAMPLE_W = 12;
   localparam logic [SAMPLE_W-1:0] SAT_MAX  = 12'd4095;

   // Right-shift the raw generator sample and clamp anything that no longer fits 12 bits.
   function automatic logic [SAMPLE_W-1:0] sat12(input logic [31:0] value, input logic [4:0] amount);
      logic [31:0] shifted;
      shifted = value >> amount;
      if (shifted > 32'(SAT_MAX))
         return SAT_MAX;
      return shifted[SAMPLE_W-1:0];
   endfunction

endpackage

// File: rtl/wave_dac_fifo.sv
// Synchronous FIFO for captured samples; a pop frees a slot for a push in the same cycle.
// DEPTH must be a power of two, at least 2.
module wave_dac_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 12
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/wave_dac.sv
// Decimating, scaling DAC output stage with sigma-delta or PWM modulation on one pin.
// Define WAVE_DAC_CAPTURE_EN to build the sample capture FIFO behind register 3.
module wave_dac
   import wave_dac_pkg::*;
#(
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  wstrb,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   input  logic [31:0] wave_in,
   output logic        dac_out,
   output logic        sample_strobe
);

   logic                sel;
   logic                wr;
   logic [1:0]          reg_idx;
   logic                ctrl_wr;
   logic                div_wr;
   logic                shift_wr;
   logic                enable;
   logic [1:0]          mode;
   logic                capture;
   logic [15:0]         div;
   logic [15:0]         divider;
   logic [4:0]          shift;
   logic [SAMPLE_W-1:0] sample;
   logic [SAMPLE_W-1:0] acc;
   logic [SAMPLE_W-1:0] ramp;
   logic [SAMPLE_W:0]   sum;
   logic                active;
   logic                tick;
   logic [31:0]         fifo_word;

   assign sel      = (addr[31:24] == BLOCK_SEL);
   assign wr       = sel && (wstrb != 4'b0000);
   assign reg_idx  = addr[3:2];
   assign ctrl_wr  = wr && (reg_idx == REG_CTRL);
   assign div_wr   = wr && (reg_idx == REG_DIV);
   assign shift_wr = wr && (reg_idx == REG_SHIFT);

   assign active = enable && (mode == MODE_SD || mode == MODE_PWM);
   assign tick   = active && (divider == div - 16'd1);
   assign sum    = {1'b0, acc} + {1'b0, sample};

   always_ff @(posedge clk) begin
      if (rst) begin
         enable <= 1'b0;
         mode   <= MODE_OFF;
         div    <= 16'd1;
         shift  <= 5'd0;
      end else begin
         if (ctrl_wr) begin
            enable <= wdata[0];
            mode   <= wdata[2:1];
         end
         if (div_wr)
            div <= (wdata[15:0] == 16'd0) ? 16'd1 : wdata[15:0];
         if (shift_wr)
            shift <= wdata[4:0];
      end
   end

   // A CTRL write restarts the whole sample path so re-enabling always begins at divider 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         divider       <= 16'd0;
         acc           <= '0;
         ramp          <= '0;
         sample        <= '0;
         dac_out       <= 1'b0;
         sample_strobe <= 1'b0;
      end else if (ctrl_wr || !active) begin
         divider       <= 16'd0;
         acc           <= '0;
         ramp          <= '0;
         dac_out       <= 1'b0;
         sample_strobe <= 1'b0;
      end else begin
         divider       <= tick ? 16'd0 : divider + 16'd1;
         sample_strobe <= tick;
         if (tick)
            sample <= sat12(wave_in, shift);
         if (mode == MODE_SD) begin
            acc     <= sum[SAMPLE_W-1:0];
            dac_out <= sum[SAMPLE_W];
         end else begin
            ramp    <= ramp + 12'd1;
            dac_out <= (ramp < sample);
         end
      end
   end

`ifdef WAVE_DAC_CAPTURE_EN
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic                fifo_wr;
   logic                push;
   logic                full;
   logic                empty;
   logic                overflow;
   logic [SAMPLE_W-1:0] head;
   logic [CW-1:0]       count;
   logic                unused_bits;

   assign fifo_wr = wr && (reg_idx == REG_FIFO);
   assign push    = sample_strobe && capture;

   always_ff @(posedge clk) begin
      if (rst)
         capture <= 1'b0;
      else if (ctrl_wr)
         capture <= wdata[3];
   end

   wave_dac_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (SAMPLE_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (fifo_wr),
      .din   (sample),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   // A pop always frees room, so it wins over a simultaneous dropped push.
   always_ff @(posedge clk) begin
      if (rst)
         overflow <= 1'b0;
      else if (fifo_wr && !empty)
         overflow <= 1'b0;
      else if (push && full)
         overflow <= 1'b1;
   end

   assign fifo_word   = {!empty, overflow, 10'd0, 4'(count), 4'd0, empty ? 12'd0 : head};
   assign unused_bits = ^{wdata[31:16], addr[23:4], addr[1:0]};
`else
   localparam int unused_depth = FIFO_DEPTH;
   logic          unused_bits;

   assign capture     = 1'b0;
   assign fifo_word   = 32'd0;
   assign unused_bits = ^{wdata[31:16], wdata[3], addr[23:4], addr[1:0]};
`endif

   always_comb begin
      rdata = 32'd0;
      if (sel) begin
         case (reg_idx)
            REG_CTRL:  rdata = {28'd0, capture, mode, enable};
            REG_DIV:   rdata = {16'd0, div};
            REG_SHIFT: rdata = {27'd0, shift};
            default:   rdata = fifo_word;
         endcase
      end
   end

endmodule

// File: tb/tb_wave_dac.sv
// Directed self-checking bench for wave_dac: register map, SD/PWM duty, decimation, capture FIFO.
module tb_wave_dac;
   import wave_dac_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  wstrb;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [31:0] wave_in;
   logic        dac_out;
   logic        sample_strobe;

   int checks = 0;
   int errors = 0;

   wave_dac #(.FIFO_DEPTH(8)) dut (
      .clk           (clk),
      .rst           (rst),
      .wstrb         (wstrb),
      .addr          (addr),
      .wdata         (wdata),
      .rdata         (rdata),
      .wave_in       (wave_in),
      .dac_out       (dac_out),
      .sample_strobe (sample_strobe)
   );

   always #5 clk = ~clk;

   // Bounds the whole run in case the bench or DUT stalls.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic applyStimulus(input logic [1:0] idx, input logic [31:0] data);
      @(negedge clk);
      addr  = {BLOCK_SEL, 20'd0, idx, 2'b00};
      wdata = data;
      wstrb = 4'hF;
      @(negedge clk);
      wstrb = 4'h0;
      wdata = 32'd0;
   endtask

   task automatic readReg(input logic [1:0] idx, output logic [31:0] value);
      addr = {BLOCK_SEL, 20'd0, idx, 2'b00};
      #1;
      value = rdata;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic countHigh(input int n, output int ones);
      ones = 0;
      repeat (n) begin
         @(negedge clk);
         ones += int'(dac_out);
      end
   endtask

   initial begin
      logic [31:0] value;
      int          ones;
      int          strobes;

      rst     = 1'b1;
      wstrb   = 4'h0;
      addr    = 32'd0;
      wdata   = 32'd0;
      wave_in = 32'd0;
      waitCycles(3);
      rst = 1'b0;

      checkOutput("reset_dac", 32'(dac_out), 32'd0);
      checkOutput("reset_strobe", 32'(sample_strobe), 32'd0);
      readReg(REG_CTRL, value);  checkOutput("reset_ctrl", value, 32'd0);
      readReg(REG_DIV, value);   checkOutput("reset_div", value, 32'd1);
      readReg(REG_SHIFT, value); checkOutput("reset_shift", value, 32'd0);
      readReg(REG_FIFO, value);  checkOutput("reset_fifo", value, 32'd0);
      addr = 32'h0600_0004;
      #1;
      checkOutput("unselected_read", rdata, 32'd0);

      // Sigma-delta at half scale: 0,0 then alternating 1,0 once the sample lands.
      wave_in = 32'd2048;
      applyStimulus(REG_DIV, 32'd1);
      applyStimulus(REG_SHIFT, 32'd0);
      applyStimulus(REG_CTRL, 32'd3);
      readReg(REG_CTRL, value); checkOutput("ctrl_sd", value, 32'd3);
      strobes = 0;
      for (int i = 1; i <= 7; i++) begin
         @(negedge clk);
         strobes += int'(sample_strobe);
         checkOutput($sformatf("sd_half_%0d", i), 32'(dac_out),
                     (i >= 3 && (i % 2) == 1) ? 32'd1 : 32'd0);
      end
      checkOutput("div1_strobe_every_cycle", 32'(strobes), 32'd7);

      wave_in = 32'd1024;
      waitCycles(3);
      countHigh(16, ones);
      checkOutput("sd_quarter_ones", 32'(ones), 32'd4);

      // PWM duty equals sample over any full 4096-cycle ramp period.
      applyStimulus(REG_CTRL, 32'd5);
      waitCycles(3);
      countHigh(4096, ones);
      checkOutput("pwm_1024", 32'(ones), 32'd1024);

      wave_in = 32'd0;
      waitCycles(3);
      countHigh(64, ones);
      checkOutput("pwm_zero", 32'(ones), 32'd0);

      wave_in = 32'd70000;
      waitCycles(3);
      countHigh(4096, ones);
      checkOutput("pwm_saturate", 32'(ones), 32'd4095);

      applyStimulus(REG_CTRL, 32'd0);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         checkOutput($sformatf("disabled_dac_%0d", i), 32'(dac_out), 32'd0);
      end

      // Decimate by 5 with >>4: strobe on every fifth cycle after enable, sample 128.
      wave_in = 32'h800;
      applyStimulus(REG_DIV, 32'd5);
      applyStimulus(REG_SHIFT, 32'd4);
      readReg(REG_DIV, value);   checkOutput("div_5", value, 32'd5);
      readReg(REG_SHIFT, value); checkOutput("shift_4", value, 32'd4);
      applyStimulus(REG_CTRL, 32'd5);
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         checkOutput($sformatf("div5_strobe_%0d", i), 32'(sample_strobe),
                     ((i % 5) == 0) ? 32'd1 : 32'd0);
      end
      waitCycles(2);
      countHigh(4096, ones);
      checkOutput("pwm_shifted_128", 32'(ones), 32'd128);

`ifdef WAVE_DAC_CAPTURE_EN
      applyStimulus(REG_CTRL, 32'd13);
      readReg(REG_CTRL, value); checkOutput("ctrl_capture", value, 32'd13);
      waitCycles(50);
      applyStimulus(REG_CTRL, 32'd0);
      readReg(REG_FIFO, value); checkOutput("fifo_full_overflow", value, 32'hC008_0080);
      applyStimulus(REG_FIFO, 32'd0);
      readReg(REG_FIFO, value); checkOutput("fifo_after_pop", value, 32'h8007_0080);
`else
      applyStimulus(REG_CTRL, 32'd13);
      readReg(REG_CTRL, value); checkOutput("ctrl_no_capture", value, 32'd5);
      readReg(REG_FIFO, value); checkOutput("fifo_absent", value, 32'd0);
      applyStimulus(REG_CTRL, 32'd0);
`endif

      applyStimulus(REG_DIV, 32'd0);
      readReg(REG_DIV, value); checkOutput("div_zero_stores_1", value, 32'd1);

      // Restart after disable, then reset mid-run.
      applyStimulus(REG_DIV, 32'd5);
      applyStimulus(REG_CTRL, 32'd5);
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         checkOutput($sformatf("reenable_strobe_%0d", i), 32'(sample_strobe),
                     (i == 5) ? 32'd1 : 32'd0);
      end
      waitCycles(3);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("midrst_dac", 32'(dac_out), 32'd0);
      checkOutput("midrst_strobe", 32'(sample_strobe), 32'd0);
      readReg(REG_CTRL, value);  checkOutput("midrst_ctrl", value, 32'd0);
      readReg(REG_DIV, value);   checkOutput("midrst_div", value, 32'd1);
      readReg(REG_SHIFT, value); checkOutput("midrst_shift", value, 32'd0);
      readReg(REG_FIFO, value);  checkOutput("midrst_fifo", value, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
